// File: rtl/cell_delay_meter_pkg.sv
// Shared definitions for the cell-chain delay meter.
//   state_t     : measurement FSM encoding
//   CNT_W_DEF   : default width of the edge counter
//   WIN_W_DEF   : default width of the window-length register
package cell_delay_meter_pkg;

    localparam int unsigned CNT_W_DEF = 16;
    localparam int unsigned WIN_W_DEF = 12;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARM     = 2'd1,
        MEASURE = 2'd2,
        DONE    = 2'd3
    } state_t;

endpackage

// File: rtl/cdm_sync2.sv
// Two-flop synchronizer bringing the free-running ring-oscillator output
// into the CLK domain.
//   CLK : sampling clock (rising edge)
//   R   : asynchronous active-low reset, clears both flops
//   d   : asynchronous input
//   q   : synchronized output
module cdm_sync2 (
    input  logic CLK,
    input  logic R,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge CLK or negedge R) begin
        if (!R) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/cell_delay_meter.sv
// Cell-chain delay meter: enables a ring oscillator for a programmable
// window of CLK cycles and counts its synchronized rising edges.
// Optional feature macro: CELL_DELAY_METER_SAT_EN
//   defined   -> count saturates at all-ones, ovf flags a lost edge
//   undefined -> count wraps modulo 2^CNT_W, ovf tied low
// Ports:
//   CLK     : clock, rising edge
//   R       : asynchronous active-low reset
//   start   : one-cycle measurement request (honoured only when idle)
//   win_len : window length in CLK cycles, sampled on accepted start
//   osc_in  : asynchronous ring-oscillator output
//   osc_en  : ring-oscillator enable (ARM and MEASURE)
//   busy    : measurement in progress (ARM, MEASURE, DONE)
//   done    : one-cycle result-valid pulse
//   count   : rising-edge count over the window
//   ovf     : count saturated
module cell_delay_meter
    import cell_delay_meter_pkg::*;
#(
    parameter int unsigned CNT_W = CNT_W_DEF,
    parameter int unsigned WIN_W = WIN_W_DEF
) (
    input  logic             CLK,
    input  logic             R,
    input  logic             start,
    input  logic [WIN_W-1:0] win_len,
    input  logic             osc_in,
    output logic             osc_en,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] count,
    output logic             ovf
);

    state_t           state;
    logic [WIN_W-1:0] remain;
    logic             osc_sync;
    logic             osc_prev;
    logic             rise;

    cdm_sync2 u_sync (
        .CLK (CLK),
        .R   (R),
        .d   (osc_in),
        .q   (osc_sync)
    );

    assign rise = osc_sync & ~osc_prev;

`ifndef CELL_DELAY_METER_SAT_EN
    assign ovf = 1'b0;
`endif

    // Outputs are registered alongside the state so each one changes on the
    // same edge as the state it belongs to.
    always_ff @(posedge CLK or negedge R) begin
        if (!R) begin
            state    <= IDLE;
            remain   <= '0;
            osc_prev <= 1'b0;
            count    <= '0;
            done     <= 1'b0;
            busy     <= 1'b0;
            osc_en   <= 1'b0;
`ifdef CELL_DELAY_METER_SAT_EN
            ovf      <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        remain <= win_len;
                        count  <= '0;
`ifdef CELL_DELAY_METER_SAT_EN
                        ovf    <= 1'b0;
`endif
                        busy   <= 1'b1;
                        osc_en <= 1'b1;
                        state  <= ARM;
                    end
                end
                ARM: begin
                    // Prime the edge detector so a level already high at
                    // arm time is not taken for an edge.
                    osc_prev <= osc_sync;
                    if (remain == '0) begin
                        osc_en <= 1'b0;
                        done   <= 1'b1;
                        state  <= DONE;
                    end else begin
                        state  <= MEASURE;
                    end
                end
                MEASURE: begin
                    osc_prev <= osc_sync;
                    if (rise) begin
`ifdef CELL_DELAY_METER_SAT_EN
                        if (count == '1) begin
                            ovf <= 1'b1;
                        end else begin
                            count <= count + CNT_W'(1);
                        end
`else
                        count <= count + CNT_W'(1);
`endif
                    end
                    if (remain == WIN_W'(1)) begin
                        osc_en <= 1'b0;
                        done   <= 1'b1;
                        state  <= DONE;
                    end else begin
                        remain <= remain - WIN_W'(1);
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy   <= 1'b0;
                    osc_en <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cell_delay_meter.sv
// Scoreboard bench for cell_delay_meter: stimulus pushes expected results,
// monitors pop and compare on every done pulse.
module tb_cell_delay_meter;

    typedef struct {
        logic [15:0] cnt;
        logic        ovf;
        int unsigned cyc;
        int unsigned en;
        int unsigned bsy;
    } exp_t;

`ifdef CELL_DELAY_METER_SAT_EN
    localparam logic [15:0] EXP4_CNT = 16'd15;
    localparam logic        EXP4_OVF = 1'b1;
`else
    localparam logic [15:0] EXP4_CNT = 16'd0;
    localparam logic        EXP4_OVF = 1'b0;
`endif

    logic        CLK;
    logic        R;
    logic        start;
    logic [11:0] win_len;
    logic        osc_in;
    logic        osc_en;
    logic        busy;
    logic        done;
    logic [15:0] count;
    logic        ovf;

    logic        start4;
    logic [11:0] win_len4;
    logic        osc_en4;
    logic        busy4;
    logic        done4;
    logic [3:0]  count4;
    logic        ovf4;

    int unsigned checks   = 0;
    int unsigned failures = 0;
    int unsigned cyc      = 0;
    int unsigned osc_per  = 0;
    logic        osc_hold = 1'b0;

    exp_t sb_q[$];
    exp_t q4[$];

    cell_delay_meter #(.CNT_W(16), .WIN_W(12)) u_dut (
        .CLK(CLK), .R(R), .start(start), .win_len(win_len), .osc_in(osc_in),
        .osc_en(osc_en), .busy(busy), .done(done), .count(count), .ovf(ovf)
    );

    cell_delay_meter #(.CNT_W(4), .WIN_W(12)) u_dut4 (
        .CLK(CLK), .R(R), .start(start4), .win_len(win_len4), .osc_in(osc_in),
        .osc_en(osc_en4), .busy(busy4), .done(done4), .count(count4), .ovf(ovf4)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    always @(posedge CLK) cyc <= cyc + 1;

    // Oscillator model: held at osc_hold when osc_per==0, else square wave.
    initial begin
        int unsigned ph;
        ph = 0;
        osc_in = 1'b0;
        forever begin
            @(negedge CLK);
            if (osc_per == 0) begin
                osc_in = osc_hold;
            end else begin
                osc_in = (ph < osc_per / 2);
                ph = (ph + 1 >= osc_per) ? 0 : ph + 1;
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
        end
    endtask

    // Main-instance monitor.
    initial begin
        exp_t e;
        int unsigned en_n;
        int unsigned bsy_n;
        en_n = 0;
        bsy_n = 0;
        forever begin
            @(negedge CLK);
            if (!R) begin
                en_n = 0;
                bsy_n = 0;
            end else begin
                if (osc_en) en_n++;
                if (busy) bsy_n++;
                if (done) begin
                    if (sb_q.size() == 0) begin
                        chk("unexpected_done", 32'(done), 32'd0);
                    end else begin
                        e = sb_q.pop_front();
                        chk("count", 32'(count), 32'(e.cnt));
                        chk("ovf", 32'(ovf), 32'(e.ovf));
                        chk("done_cycle", cyc, e.cyc);
                        chk("osc_en_cycles", en_n, e.en);
                        chk("busy_cycles", bsy_n, e.bsy);
                    end
                    en_n = 0;
                    bsy_n = 0;
                end
            end
        end
    end

    // Narrow-counter instance monitor.
    initial begin
        exp_t e;
        forever begin
            @(negedge CLK);
            if (R && done4) begin
                if (q4.size() == 0) begin
                    chk("unexpected_done4", 32'(done4), 32'd0);
                end else begin
                    e = q4.pop_front();
                    chk("count4", 32'(count4), 32'(e.cnt));
                    chk("ovf4", 32'(ovf4), 32'(e.ovf));
                    chk("done_cycle4", cyc, e.cyc);
                end
            end
        end
    end

    task automatic launch(input int unsigned wl, input logic [15:0] ec, input logic eo,
                          output int unsigned s);
        exp_t e;
        @(negedge CLK);
        start = 1'b1;
        win_len = 12'(wl);
        s = cyc;
        e.cnt = ec; e.ovf = eo; e.cyc = s + wl + 2; e.en = wl + 1; e.bsy = wl + 2;
        sb_q.push_back(e);
        @(negedge CLK);
        start = 1'b0;
    endtask

    task automatic settle(input int unsigned n, input logic [15:0] ec);
        repeat (n) @(negedge CLK);
        chk("done_timeout", sb_q.size(), 32'd0);
        sb_q.delete();
        chk("count_hold", 32'(count), 32'(ec));
    endtask

    initial begin
        int unsigned s;
        exp_t e;
        R = 1'b1; start = 1'b0; win_len = '0; start4 = 1'b0; win_len4 = '0;
        #2 R = 1'b0;
        repeat (3) @(negedge CLK);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_ovf", 32'(ovf), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_osc_en", 32'(osc_en), 32'd0);
        @(negedge CLK);
        R = 1'b1;

        // Oscillator already high when armed: no edge may be counted.
        osc_per = 0; osc_hold = 1'b1;
        repeat (5) @(negedge CLK);
        launch(20, 16'd0, 1'b0, s);
        settle(30, 16'd0);

        // Edge every 4 cycles over a 100-cycle window.
        osc_per = 4;
        repeat (4) @(negedge CLK);
        launch(100, 16'd25, 1'b0, s);
        settle(110, 16'd25);

        // Zero-length window.
        launch(0, 16'd0, 1'b0, s);
        settle(10, 16'd0);

        // Second start mid-measurement is ignored.
        osc_per = 2;
        launch(50, 16'd25, 1'b0, s);
        while (cyc != s + 10) @(negedge CLK);
        start = 1'b1; win_len = 12'd7;
        @(negedge CLK);
        start = 1'b0;
        settle(60, 16'd25);

        // Reset mid-measurement discards the result.
        osc_per = 4;
        launch(100, 16'd25, 1'b0, s);
        while (cyc != s + 30) @(negedge CLK);
        chk("busy_mid", 32'(busy), 32'd1);
        R = 1'b0;
        #1;
        chk("mid_rst_count", 32'(count), 32'd0);
        chk("mid_rst_osc_en", 32'(osc_en), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        sb_q.delete();
        repeat (3) @(negedge CLK);
        R = 1'b1;
        repeat (150) @(negedge CLK);
        chk("post_rst_busy", 32'(busy), 32'd0);

        // Narrow counter: saturate or wrap depending on build.
        osc_per = 2;
        @(negedge CLK);
        start4 = 1'b1;
        win_len4 = 12'd64;
        e.cnt = EXP4_CNT; e.ovf = EXP4_OVF; e.cyc = cyc + 66; e.en = 0; e.bsy = 0;
        q4.push_back(e);
        @(negedge CLK);
        start4 = 1'b0;
        repeat (75) @(negedge CLK);
        chk("done4_timeout", q4.size(), 32'd0);
        q4.delete();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
